// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: FSM states, error causes,
// buffer entry layout and the default frame delimiter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_OVF  = 2'd3
  } err_cause_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } buf_entry_t;

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Downstream valid/ready byte stream with end-of-frame marker.
interface uart_rx_frame_parser_if;
  logic       o_Valid;
  logic       i_Ready;
  logic [7:0] o_Data;
  logic       o_Last;

  modport master (output o_Valid, output o_Data, output o_Last, input i_Ready);
  modport slave  (input o_Valid, input o_Data, input o_Last, output i_Ready);
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer with a speculative write region: entries become visible to
// the reader only on commit, and a rollback forgets everything since.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  buf_entry_t wr_entry_i,
  input  logic       commit_i,
  input  logic       rollback_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       valid_o,
  output buf_entry_t rd_entry_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  buf_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          wr_fire;

  // The extra pointer bit distinguishes full from empty with no extra state.
  assign full_o     = (wr_q - rd_q) == DEPTH_P;
  assign valid_o    = cm_q != rd_q;
  assign wr_fire    = wr_en_i && !full_o;
  assign rd_entry_o = valid_o ? mem_q[rd_q[AW-1:0]] : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_d = wr_q;
    cm_d = cm_q;
    rd_d = rd_q;
    if (rollback_i)   wr_d = cm_q;
    else if (wr_fire) wr_d = wr_q + PW'(1);
    if (commit_i)     cm_d = wr_q;
    if (pop_i)        rd_d = rd_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_q[AW-1:0]] <= wr_entry_i;
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Extracts SYNC/LEN/payload/CSUM frames from the UART byte strobes and
// releases payload downstream only once the checksum has verified.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN   = 16,
  parameter int         DEPTH     = 32
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Rx_DV,
  input  logic [7:0]                    i_Rx_Byte,
  uart_rx_frame_parser_if.master        out_if,
  output logic                          o_Frame_Ok,
  output logic                          o_Frame_Err,
  output logic [1:0]                    o_Err_Cause
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic       drop_q, drop_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  err_cause_e cause_q, cause_d;

  logic       buf_wr_en, buf_commit, buf_rollback, buf_pop;
  logic       buf_full, buf_valid;
  buf_entry_t buf_wr_entry, buf_rd_entry;
  logic [7:0] cnt_inc, sum_fin;

  assign cnt_inc = cnt_q + 8'd1;
  assign sum_fin = sum_q + i_Rx_Byte;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    drop_d       = drop_q;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    cause_d      = ERR_NONE;
    buf_wr_en    = 1'b0;
    buf_wr_entry = '0;
    buf_commit   = 1'b0;
    buf_rollback = 1'b0;
    if (i_Rx_DV) begin
      unique case (state_q)
        S_SYNC: begin
          if (i_Rx_Byte == SYNC_BYTE) state_d = S_LEN;
        end
        S_LEN: begin
          if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
            err_d   = 1'b1;
            cause_d = ERR_LEN;
            state_d = S_SYNC;
          end else begin
            len_d   = i_Rx_Byte;
            sum_d   = i_Rx_Byte;
            cnt_d   = 8'd0;
            drop_d  = 1'b0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          sum_d        = sum_fin;
          cnt_d        = cnt_inc;
          buf_wr_entry = '{last: (cnt_inc == len_q), data: i_Rx_Byte};
          // Once a byte is dropped the frame is doomed; stop writing for good.
          if (!drop_q) begin
            if (buf_full) drop_d    = 1'b1;
            else          buf_wr_en = 1'b1;
          end
          if (cnt_inc == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (drop_q) begin
            err_d        = 1'b1;
            cause_d      = ERR_OVF;
            buf_rollback = 1'b1;
          end else if (sum_fin != 8'd0) begin
            err_d        = 1'b1;
            cause_d      = ERR_CSUM;
            buf_rollback = 1'b1;
          end else begin
            ok_d       = 1'b1;
            buf_commit = 1'b1;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      drop_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      drop_q  <= drop_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  assign buf_pop = buf_valid && out_if.i_Ready;

  uart_frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (i_Clock),
    .rst        (i_Reset),
    .wr_en_i    (buf_wr_en),
    .wr_entry_i (buf_wr_entry),
    .commit_i   (buf_commit),
    .rollback_i (buf_rollback),
    .pop_i      (buf_pop),
    .full_o     (buf_full),
    .valid_o    (buf_valid),
    .rd_entry_o (buf_rd_entry)
  );

  assign out_if.o_Valid = buf_valid;
  assign out_if.o_Data  = buf_rd_entry.data;
  assign out_if.o_Last  = buf_rd_entry.last;
  assign o_Frame_Ok     = ok_q;
  assign o_Frame_Err    = err_q;
  assign o_Err_Cause    = cause_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Randomised and directed bench for uart_rx_frame_parser, checked every cycle
// against a queue-based frame model.
module tb_uart_rx_frame_parser;

  localparam int DEPTH   = 32;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       o_Frame_Ok, o_Frame_Err;
  logic [1:0] o_Err_Cause;

  uart_rx_frame_parser_if out_if ();

  uart_rx_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .out_if      (out_if.master),
    .o_Frame_Ok  (o_Frame_Ok),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Cause (o_Err_Cause)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;
  int rdy_mode = 0;  // 0: hold off, 1: always ready, 2: random

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed bytes wait in outq, the frame in progress in spec.
  logic [8:0] outq[$];
  logic [8:0] spec[$];
  logic [7:0] fbytes[$];
  int         phase = 0;  // 0 wait sync, 1 wait len, 2 payload, 3 checksum
  int         flen = 0;
  bit         drop = 1'b0;
  logic       exp_ok = 1'b0, exp_err = 1'b0;
  logic [1:0] exp_cause = 2'd0;

  initial forever begin
    @(posedge clk);
    if (i_Reset) begin
      outq.delete(); spec.delete(); fbytes.delete();
      phase = 0; drop = 1'b0;
      exp_ok = 1'b0; exp_err = 1'b0; exp_cause = 2'd0;
    end else begin
      bit pop;
      int s;
      pop = (outq.size() != 0) && out_if.i_Ready;
      exp_ok = 1'b0; exp_err = 1'b0; exp_cause = 2'd0;
      if (i_Rx_DV) begin
        case (phase)
          0: if (i_Rx_Byte == 8'hA5) phase = 1;
          1: if (i_Rx_Byte == 8'd0 || int'(i_Rx_Byte) > MAX_LEN) begin
               exp_err = 1'b1; exp_cause = 2'd1; phase = 0;
             end else begin
               flen = int'(i_Rx_Byte); drop = 1'b0;
               spec.delete(); fbytes.delete(); phase = 2;
             end
          2: begin
               fbytes.push_back(i_Rx_Byte);
               if (!drop) begin
                 if (outq.size() + spec.size() == DEPTH) drop = 1'b1;
                 else spec.push_back({fbytes.size() == flen, i_Rx_Byte});
               end
               if (fbytes.size() == flen) phase = 3;
             end
          default: begin
               s = flen + int'(i_Rx_Byte);
               foreach (fbytes[i]) s += int'(fbytes[i]);
               if (drop) begin
                 exp_err = 1'b1; exp_cause = 2'd3;
               end else if (s % 256 != 0) begin
                 exp_err = 1'b1; exp_cause = 2'd2;
               end else begin
                 exp_ok = 1'b1;
                 foreach (spec[i]) outq.push_back(spec[i]);
               end
               spec.delete(); phase = 0;
             end
        endcase
      end
      if (pop) void'(outq.pop_front());
    end
  end

  // Compare process plus a sink recording what the consumer actually received.
  logic [8:0] got[$];
  int         ok_cnt = 0, err_cnt = 0;
  logic [1:0] last_cause = 2'd0;

  initial forever begin
    @(negedge clk);
    if (armed) begin
      logic [8:0] head;
      head = (outq.size() != 0) ? outq[0] : 9'h000;
      check("valid", int'(out_if.o_Valid), int'(outq.size() != 0));
      check("data", int'(out_if.o_Data), int'(head[7:0]));
      check("last", int'(out_if.o_Last), int'(head[8]));
      check("frame_ok", int'(o_Frame_Ok), int'(exp_ok));
      check("frame_err", int'(o_Frame_Err), int'(exp_err));
      check("err_cause", int'(o_Err_Cause), int'(exp_cause));
      if (out_if.o_Valid && out_if.i_Ready) got.push_back({out_if.o_Last, out_if.o_Data});
      if (o_Frame_Ok) ok_cnt++;
      if (o_Frame_Err) begin
        err_cnt++;
        last_cause = o_Err_Cause;
      end
    end
  end

  initial begin
    out_if.i_Ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_if.i_Ready = 1'b0;
        1:       out_if.i_Ready = 1'b1;
        default: out_if.i_Ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    i_Rx_DV = 1'b1; i_Rx_Byte = b;
    step();
    i_Rx_DV = 1'b0;
    repeat (gap) step();
  endtask

  logic [7:0] pkt[$];

  task automatic send_pkt(input int gap);
    foreach (pkt[i]) send(pkt[i], gap);
    pkt.delete();
  endtask

  // Builds SYNC, LEN, payload, CSUM; corrupt flips the checksum.
  task automatic build_frame(input int len, input bit corrupt, input logic [7:0] base);
    logic [7:0] s;
    s = 8'(len);
    pkt.push_back(8'hA5);
    pkt.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = (base == 8'h00) ? 8'($urandom) : 8'(base + 8'(i));
      pkt.push_back(b);
      s = s + b;
    end
    pkt.push_back(8'(-s) ^ (corrupt ? 8'h01 : 8'h00));
  endtask

  initial begin
    int e0;
    i_Reset = 1'b1;
    repeat (3) step();
    i_Reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(out_if.o_Valid), 0);
    check("reset_data", int'(out_if.o_Data), 0);
    step();

    // Basic good frame.
    rdy_mode = 1; step();
    got.delete(); ok_cnt = 0; err_cnt = 0;
    pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_pkt(1); repeat (6) step();
    check("basic_count", got.size(), 3);
    if (got.size() == 3) begin
      check("basic_b0", int'(got[0]), 'h011);
      check("basic_b1", int'(got[1]), 'h022);
      check("basic_b2", int'(got[2]), 'h133);
    end
    check("basic_ok", ok_cnt, 1);
    check("basic_err", err_cnt, 0);

    // Bad checksum, then the good frame again.
    got.delete(); ok_cnt = 0; err_cnt = 0;
    pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_pkt(0); repeat (4) step();
    check("csum_err", err_cnt, 1);
    check("csum_cause", int'(last_cause), 2);
    check("csum_no_out", got.size(), 0);
    pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_pkt(0); repeat (6) step();
    check("after_csum_count", got.size(), 3);

    // Junk then zero length; then over-long length.
    err_cnt = 0;
    pkt = '{8'hFF, 8'h00, 8'hA5, 8'h00};
    send_pkt(1); repeat (2) step();
    check("len0_err", err_cnt, 1);
    check("len0_cause", int'(last_cause), 1);
    pkt = '{8'hA5, 8'h11};
    send_pkt(1); repeat (2) step();
    check("len17_err", err_cnt, 2);
    check("len17_cause", int'(last_cause), 1);

    // Fill the buffer with two 16-byte frames, third overflows, then drain.
    rdy_mode = 0; repeat (2) step();
    got.delete(); ok_cnt = 0; err_cnt = 0;
    build_frame(16, 1'b0, 8'h10); send_pkt(0);
    build_frame(16, 1'b0, 8'h40); send_pkt(0);
    build_frame(16, 1'b0, 8'h70); send_pkt(0);
    repeat (3) step();
    check("ovf_ok", ok_cnt, 2);
    check("ovf_cause", int'(last_cause), 3);
    check("ovf_nothing_read", got.size(), 0);
    rdy_mode = 1;
    repeat (40) step();
    check("drain_count", got.size(), 32);
    if (got.size() == 32) begin
      check("drain_first", int'(got[0]), 'h010);
      check("drain_last16", int'(got[15]), 'h11F);
      check("drain_b17", int'(got[16]), 'h040);
      check("drain_last32", int'(got[31]), 'h14F);
    end
    got.delete();
    pkt = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    send_pkt(0); repeat (4) step();
    check("after_drain_count", got.size(), 1);
    if (got.size() == 1) check("after_drain_byte", int'(got[0]), 'h15A);

    // Reset mid-frame with a committed frame still unread.
    rdy_mode = 0; repeat (2) step();
    pkt = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    send_pkt(0); step();
    pkt = '{8'hA5, 8'h03, 8'h11};
    send_pkt(0);
    i_Reset = 1'b1; step(); i_Reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", int'(out_if.o_Valid), 0);
    step();
    rdy_mode = 1; got.delete();
    pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_pkt(0); repeat (6) step();
    check("post_rst_count", got.size(), 3);

    // Back-to-back frames with the consumer always ready.
    got.delete(); ok_cnt = 0;
    for (int f = 0; f < 20; f++) begin
      build_frame(int'($urandom_range(1, MAX_LEN)), 1'b0, 8'h00);
      send_pkt(0);
    end
    repeat (20) step();
    check("b2b_ok", ok_cnt, 20);

    // Random mix of good, corrupt, bad-length and junk traffic.
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       build_frame(int'($urandom_range(1, MAX_LEN)), 1'b0, 8'h00);
      else if (kind < 8)  build_frame(int'($urandom_range(1, MAX_LEN)), 1'b1, 8'h00);
      else if (kind == 8) pkt = '{8'hA5, 8'(MAX_LEN + int'($urandom_range(1, 200)))};
      else                pkt = '{8'(8'h00 + 8'($urandom_range(0, 160))), 8'h3C};
      send_pkt(int'($urandom_range(0, 2)));
    end
    rdy_mode = 1;
    repeat (60) step();
    e0 = n_cmp;
    check("final_empty", int'(out_if.o_Valid), 0);
    if (n_cmp == e0) n_bad++;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
